// File: rtl/skolem_witness_checker_if.sv
// Candidate-triple handshake between the Skolem-function stage and the witness checker.
// The master drives a triple; the slave returns a one-cycle verdict.
interface skolem_witness_checker_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic [W-1:0] x;
    logic         out_valid;
    logic         out_ok;

    modport master (
        output in_valid, s, t, x,
        input  in_ready, out_valid, out_ok
    );

    modport slave (
        input  in_valid, s, t, x,
        output in_ready, out_valid, out_ok
    );
endinterface

// File: rtl/skolem_witness_checker.sv
// Checks the invertibility predicate (dividend urem divisor) <u t for each accepted triple,
// using a W-cycle restoring remainder unit, and keeps saturating pass/fail statistics.
module skolem_witness_checker #(
    parameter int W   = 4,
    parameter int POS = 1,
    parameter int CW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    skolem_witness_checker_if.slave bus,
    output logic [CW-1:0]          pass_cnt,
    output logic [CW-1:0]          fail_cnt,
    output logic                   fail_seen,
    output logic [W-1:0]           fail_s,
    output logic [W-1:0]           fail_t,
    output logic [W-1:0]           fail_x
);
    localparam int SW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RES  = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   s_q;
    logic [W-1:0]   t_q;
    logic [W-1:0]   x_q;
    logic [W:0]     rem_q;
    logic [W-1:0]   quo_q;
    logic [SW-1:0]  step_q;
    logic           out_valid_q;
    logic           out_ok_q;
    logic [CW-1:0]  pass_cnt_q;
    logic [CW-1:0]  fail_cnt_q;
    logic           fail_seen_q;
    logic [W-1:0]   fail_s_q;
    logic [W-1:0]   fail_t_q;
    logic [W-1:0]   fail_x_q;

    logic [W-1:0]   divisor;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_d;
    logic [W-1:0]   quo_d;
    logic           ok_res;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    // A zero divisor always "fits" and subtracts nothing, so the remainder ends equal to the dividend.
    always_comb begin
        divisor = (POS != 0) ? x_q : s_q;
        rem_sh  = {rem_q[W-1:0], quo_q[W-1]};
        rem_d   = rem_sh;
        quo_d   = quo_q << 1;
        if (rem_sh >= {1'b0, divisor}) begin
            rem_d = rem_sh - {1'b0, divisor};
            quo_d = (quo_q << 1) | W'(1);
        end
    end

    assign ok_res = (rem_q < {1'b0, t_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_ok_q    <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            fail_seen_q <= 1'b0;
            fail_s_q    <= '0;
            fail_t_q    <= '0;
            fail_x_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_ok_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_q     <= bus.s;
                        t_q     <= bus.t;
                        x_q     <= bus.x;
                        quo_q   <= (POS != 0) ? bus.s : bus.x;
                        rem_q   <= '0;
                        step_q  <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    step_q <= step_q + SW'(1);
                    if (step_q == SW'(W - 1)) begin
                        state_q <= RES;
                    end
                end
                RES: begin
                    // Verdict and statistics are registered together on the edge leaving RES.
                    out_valid_q <= 1'b1;
                    out_ok_q    <= ok_res;
                    if (ok_res) begin
                        pass_cnt_q <= sat_inc(pass_cnt_q);
                    end else begin
                        fail_cnt_q <= sat_inc(fail_cnt_q);
                        if (!fail_seen_q) begin
                            fail_seen_q <= 1'b1;
                            fail_s_q    <= s_q;
                            fail_t_q    <= t_q;
                            fail_x_q    <= x_q;
                        end
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_ok    = out_ok_q;
    assign pass_cnt      = pass_cnt_q;
    assign fail_cnt      = fail_cnt_q;
    assign fail_seen     = fail_seen_q;
    assign fail_s        = fail_s_q;
    assign fail_t        = fail_t_q;
    assign fail_x        = fail_x_q;
endmodule
